zevt_window_counter: RTL and testbench
======================================

Name: zevt_window_counter

Overview:
- Downstream consumer of the 2012_q2 pattern FSM's z output.
- Detects z assertion events (0->1 transitions) and measures z high-run lengths over fixed windows of WINDOW cycles.
- Presents one result per window to a status/interrupt stage over a valid/ready handshake.
- Reports results the consumer could not accept through a sticky drop flag.

Parameters:
WINDOW, 64, window length in clk cycles (>=2)
CNT_W, 8, width of event count, saturating
RUN_W, 8, width of max high-run length, saturating

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  run windows while high
z  input  1  detector output, sampled every cycle
out_ready  input  1  consumer accepts result
out_valid  output  1  result register holds unconsumed result
out_count  output  CNT_W  z rising edges in the reported window
out_maxrun  output  RUN_W  longest consecutive z=1 run in the reported window
out_dropped  output  1  sticky: a window result was discarded

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk.
- On reset, all of the following go to 0: state=IDLE, timer, evt_cnt, run, maxrun, z_q, out_valid, out_count, out_maxrun, out_dropped. Reset mid-window or mid-handshake discards everything.
- z_q: registers z every cycle regardless of state. Rising edge = z & ~z_q.
- IDLE state:
  - Accumulators (timer, evt_cnt, run, maxrun) held at 0.
  - enable=1 at a clock edge -> COUNT next cycle with timer=0.
  - enable=0 in IDLE clears out_dropped.
- COUNT state: each cycle with enable=1:
  - evt_cnt += rising edge, saturating at 2^CNT_W-1.
  - run = z ? sat(run+1) : 0.
  - maxrun = max(maxrun, new run).
  - timer increments.
- Window close: on the cycle timer==WINDOW-1, that cycle's sample is included.
  - Final evt_cnt and maxrun form the result.
  - timer, evt_cnt, run and maxrun clear, so a run straddling the boundary is split.
  - State stays COUNT.
- Result delivery:
  - If out_valid=0, or out_valid&out_ready in the same cycle: result loads into out_count/out_maxrun; out_valid=1 next cycle. Latency is 1 cycle after the closing sample.
  - If out_valid=1 and out_ready=0: new result is discarded, held result stays unchanged, out_dropped=1 next cycle.
- Handshake:
  - out_valid&out_ready with no window close -> out_valid=0 next cycle.
  - out_count and out_maxrun are stable while out_valid=1 and out_ready=0.
- enable=0 in COUNT: partial window abandoned without a result; IDLE next cycle. A pending result stays valid until consumed.
- A z edge on the first cycle after reset counts, because z_q resets to 0.
- Only edges count: z held high across a window boundary does not count in the new window.
- out_dropped is cleared only by reset or by enable=0 in IDLE.

Optional Feature:
- Macro: ZEVT_WINDOW_ID_EN.
- Defined:
  - Adds output out_window_id (16 bits), reset 0.
  - An internal 16-bit window sequence number increments, with wrap, at every window close, including dropped windows.
  - The value at close is loaded alongside out_count whenever a result loads, so the consumer can detect gaps.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Bench parameters: WINDOW=8, CNT_W=4, RUN_W=4 unless noted.
- Pulse train: reset, enable=1, out_ready=1, z=1,0,1,0,1,0,0,0 -> out_valid=1 one cycle after the 8th sample, out_count=3, out_maxrun=1, for 1 cycle.
- Long run: z=0,1,1,1,1,1,0,0 -> out_count=1, out_maxrun=5; next window with z=0 throughout -> out_count=0, out_maxrun=0.
- Saturation: CNT_W=2, RUN_W=2; z=1,0,1,0,1,0,1,1 -> out_count=3 (4 edges saturated), out_maxrun=2.
- Backpressure: out_ready=0 across two window closes (counts 2, then 4) -> out_count stays 2, out_dropped=1. Then out_ready=1 for one cycle -> out_valid=0; out_dropped stays 1 until enable=0 in IDLE.
- Abort: enable drops at timer=3 after 2 edges -> no out_valid, IDLE. Re-enable -> fresh window, count excludes the earlier edges.
- Reset mid-operation: reset while out_valid=1 and timer=5 -> all outputs 0 the next cycle, IDLE. With ZEVT_WINDOW_ID_EN defined, out_window_id=0; the first result after re-enable carries window_id 0.

Source files
------------

// File: rtl/zevt_window_counter.sv
// Windowed z-event counter: counts z rising edges and the longest z-high run per
// WINDOW-cycle window, delivering one result per window over valid/ready.
// Optional macro ZEVT_WINDOW_ID_EN adds a 16-bit window sequence id (out_window_id).
module zevt_window_counter #(
   parameter int WINDOW = 64,
   parameter int CNT_W  = 8,
   parameter int RUN_W  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             z,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [CNT_W-1:0] out_count,
   output logic [RUN_W-1:0] out_maxrun,
   output logic             out_dropped
`ifdef ZEVT_WINDOW_ID_EN
   ,
   output logic [15:0]      out_window_id
`endif
);

   localparam int TMR_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
   localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [RUN_W-1:0] RUN_MAX    = {RUN_W{1'b1}};

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   state_t           state_reg;
   logic [TMR_W-1:0] timer_reg;
   logic [CNT_W-1:0] evt_cnt_reg;
   logic [RUN_W-1:0] run_reg;
   logic [RUN_W-1:0] maxrun_reg;
   logic             z_q_reg;

   logic             rise;
   logic [CNT_W-1:0] evt_cnt_next;
   logic [RUN_W-1:0] run_next;
   logic [RUN_W-1:0] maxrun_next;
   logic             win_close;
   logic             load_result;

`ifdef ZEVT_WINDOW_ID_EN
   logic [15:0]      win_seq_reg;
`endif

   // Accumulator update for the current sample, all saturating.
   always_comb begin
      rise         = z & ~z_q_reg;
      evt_cnt_next = evt_cnt_reg;
      if (rise && (evt_cnt_reg != CNT_MAX))
         evt_cnt_next = evt_cnt_reg + 1'b1;
      run_next = '0;
      if (z)
         run_next = (run_reg == RUN_MAX) ? run_reg : run_reg + 1'b1;
      maxrun_next = (run_next > maxrun_reg) ? run_next : maxrun_reg;
   end

   assign win_close   = (state_reg == COUNT) && enable && (timer_reg == TIMER_LAST);
   // A closing window may load into a slot that is being emptied this same cycle.
   assign load_result = win_close && (!out_valid || out_ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         timer_reg   <= '0;
         evt_cnt_reg <= '0;
         run_reg     <= '0;
         maxrun_reg  <= '0;
         z_q_reg     <= 1'b0;
         out_valid   <= 1'b0;
         out_count   <= '0;
         out_maxrun  <= '0;
         out_dropped <= 1'b0;
      end else begin
         z_q_reg <= z;

         case (state_reg)
            IDLE: begin
               timer_reg   <= '0;
               evt_cnt_reg <= '0;
               run_reg     <= '0;
               maxrun_reg  <= '0;
               if (enable)
                  state_reg <= COUNT;
               else
                  out_dropped <= 1'b0;
            end
            COUNT: begin
               if (!enable || (timer_reg == TIMER_LAST)) begin
                  // Abort or window close: a run straddling the boundary is split.
                  timer_reg   <= '0;
                  evt_cnt_reg <= '0;
                  run_reg     <= '0;
                  maxrun_reg  <= '0;
                  if (!enable)
                     state_reg <= IDLE;
               end else begin
                  timer_reg   <= timer_reg + 1'b1;
                  evt_cnt_reg <= evt_cnt_next;
                  run_reg     <= run_next;
                  maxrun_reg  <= maxrun_next;
               end
            end
            default: state_reg <= IDLE;
         endcase

         if (load_result) begin
            out_valid  <= 1'b1;
            out_count  <= evt_cnt_next;
            out_maxrun <= maxrun_next;
         end else if (win_close) begin
            out_dropped <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef ZEVT_WINDOW_ID_EN
   // Sequence advances on every close, dropped or not, so gaps are visible downstream.
   always_ff @(posedge clk) begin
      if (reset) begin
         win_seq_reg   <= '0;
         out_window_id <= '0;
      end else if (win_close) begin
         win_seq_reg <= win_seq_reg + 16'd1;
         if (load_result)
            out_window_id <= win_seq_reg;
      end
   end
`endif

endmodule

// File: tb/tb_zevt_window_counter.sv
// Directed bench for zevt_window_counter (WINDOW=8, CNT_W=RUN_W=4) plus a
// narrow CNT_W=RUN_W=2 instance sharing the same stimulus for saturation.
module tb_zevt_window_counter;

   localparam int WINDOW = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       z;
   logic       out_ready;
   logic       out_valid;
   logic [3:0] out_count;
   logic [3:0] out_maxrun;
   logic       out_dropped;
   logic       sat_valid;
   logic [1:0] sat_count;
   logic [1:0] sat_maxrun;
   logic       sat_dropped;
`ifdef ZEVT_WINDOW_ID_EN
   logic [15:0] out_window_id;
   logic [15:0] sat_window_id;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   zevt_window_counter #(.WINDOW(WINDOW), .CNT_W(4), .RUN_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .z           (z),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_count   (out_count),
      .out_maxrun  (out_maxrun),
      .out_dropped (out_dropped)
`ifdef ZEVT_WINDOW_ID_EN
      ,
      .out_window_id (out_window_id)
`endif
   );

   zevt_window_counter #(.WINDOW(WINDOW), .CNT_W(2), .RUN_W(2)) dut_sat (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .z           (z),
      .out_ready   (out_ready),
      .out_valid   (sat_valid),
      .out_count   (sat_count),
      .out_maxrun  (sat_maxrun),
      .out_dropped (sat_dropped)
`ifdef ZEVT_WINDOW_ID_EN
      ,
      .out_window_id (sat_window_id)
`endif
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
      $display("check %-22s observed=%0d expected=%0d", tag, observed, expected);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input logic zv);
      z = zv;
      tick();
   endtask

   // Samples are applied left to right from the literal.
   task automatic apply_n(input logic [0:7] bits, input int n);
      for (int i = 0; i < n; i++)
         apply(bits[i]);
   endtask

   initial begin
      reset     = 1'b1;
      enable    = 1'b0;
      z         = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      check("reset_valid",   32'(out_valid),   0);
      check("reset_count",   32'(out_count),   0);
      check("reset_maxrun",  32'(out_maxrun),  0);
      check("reset_dropped", 32'(out_dropped), 0);

      // Pulse train
      reset     = 1'b0;
      enable    = 1'b1;
      out_ready = 1'b1;
      apply(1'b0);
      apply_n(8'b10101000, 7);
      check("pulse_latency_valid", 32'(out_valid), 0);
      apply(1'b0);
      check("pulse_valid",  32'(out_valid),  1);
      check("pulse_count",  32'(out_count),  3);
      check("pulse_maxrun", 32'(out_maxrun), 1);
`ifdef ZEVT_WINDOW_ID_EN
      check("pulse_id", 32'(out_window_id), 0);
`endif

      // Long run, then an all-zero window
      apply(1'b0);
      check("pulse_consumed", 32'(out_valid), 0);
      apply_n(8'b11111000, 7);
      check("long_valid",  32'(out_valid),  1);
      check("long_count",  32'(out_count),  1);
      check("long_maxrun", 32'(out_maxrun), 5);
      apply(1'b0);
      check("long_consumed", 32'(out_valid), 0);
      apply_n(8'b00000000, 7);
      check("zero_valid",  32'(out_valid),  1);
      check("zero_count",  32'(out_count),  0);
      check("zero_maxrun", 32'(out_maxrun), 0);

      // Saturation on the narrow instance
      apply_n(8'b10101011, 8);
      check("wide_count",  32'(out_count),  4);
      check("wide_maxrun", 32'(out_maxrun), 2);
      check("sat_valid",   32'(sat_valid),  1);
      check("sat_count",   32'(sat_count),  3);
      check("sat_maxrun",  32'(sat_maxrun), 2);
`ifdef ZEVT_WINDOW_ID_EN
      check("sat_id", 32'(out_window_id), 3);
`endif

      // Backpressure across two closes
      apply(1'b0);
      check("bp_consumed", 32'(out_valid), 0);
      out_ready = 1'b0;
      apply_n(8'b10100000, 7);
      check("bp_a_valid",   32'(out_valid),   1);
      check("bp_a_count",   32'(out_count),   2);
      check("bp_a_dropped", 32'(out_dropped), 0);
      apply_n(8'b11010101, 8);
      check("bp_b_valid",   32'(out_valid),   1);
      check("bp_b_count",   32'(out_count),   2);
      check("bp_b_maxrun",  32'(out_maxrun),  1);
      check("bp_b_dropped", 32'(out_dropped), 1);
`ifdef ZEVT_WINDOW_ID_EN
      check("bp_b_id", 32'(out_window_id), 4);
`endif
      out_ready = 1'b1;
      apply(1'b0);
      check("bp_drain_valid",   32'(out_valid),   0);
      check("bp_drain_dropped", 32'(out_dropped), 1);
      enable = 1'b0;
      apply(1'b0);
      check("drop_kept_to_idle", 32'(out_dropped), 1);
      apply(1'b0);
      check("drop_cleared_idle", 32'(out_dropped), 0);

      // Abort at timer=3 after two edges, then a fresh window
      enable = 1'b1;
      apply(1'b0);
      apply_n(8'b10100000, 3);
      enable = 1'b0;
      apply(1'b0);
      check("abort_no_valid", 32'(out_valid), 0);
      enable = 1'b1;
      apply(1'b0);
      apply_n(8'b10000000, 7);
      check("fresh_latency_valid", 32'(out_valid), 0);
      apply(1'b0);
      check("fresh_valid",  32'(out_valid),  1);
      check("fresh_count",  32'(out_count),  1);
      check("fresh_maxrun", 32'(out_maxrun), 1);
`ifdef ZEVT_WINDOW_ID_EN
      check("fresh_id", 32'(out_window_id), 6);
`endif

      // Reset while a result is pending and timer=5
      out_ready = 1'b0;
      apply_n(8'b00000000, 5);
      check("pre_reset_valid", 32'(out_valid), 1);
      reset = 1'b1;
      tick();
      check("mid_reset_valid",   32'(out_valid),   0);
      check("mid_reset_count",   32'(out_count),   0);
      check("mid_reset_maxrun",  32'(out_maxrun),  0);
      check("mid_reset_dropped", 32'(out_dropped), 0);
`ifdef ZEVT_WINDOW_ID_EN
      check("mid_reset_id", 32'(out_window_id), 0);
`endif
      reset     = 1'b0;
      out_ready = 1'b1;
      apply(1'b0);
      apply_n(8'b11000000, 8);
      check("post_reset_valid",  32'(out_valid),  1);
      check("post_reset_count",  32'(out_count),  1);
      check("post_reset_maxrun", 32'(out_maxrun), 2);
`ifdef ZEVT_WINDOW_ID_EN
      check("post_reset_id", 32'(out_window_id), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
